// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, response codes, FSM state encoding and timeout sizing
// for the SPI command decoder.
package spi_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] RSP_ACK  = 8'hA5;
  localparam logic [7:0] RSP_ERR  = 8'hEE;

  localparam int TIMEOUT_CYCLES_DEF = 1000000;

  function automatic int tmo_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  localparam int TMO_W_DEF = tmo_width(TIMEOUT_CYCLES_DEF);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_OP,
    ST_GET_ADDR,
    ST_GET_LEN,
    ST_WR_DATA,
    ST_WR_STB,
    ST_RD_REQ,
    ST_RD_CAP,
    ST_RSP,
    ST_ERR
  } state_e;

endpackage

// File: rtl/spi_cmd_timeout.sv
// Inter-byte watchdog: reloads on clr, counts down while en is high and
// pulses expired on the TIMEOUT_CYCLES-th consecutive enabled cycle.
module spi_cmd_timeout
  import spi_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = tmo_width(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= LOAD;
    end else if (clr) begin
      cnt_q <= LOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired = en && !clr && (cnt_q == W'(1));

endmodule

// File: rtl/spi_cmd_decoder.sv
// Parses OPCODE/ADDR/LEN frames from the SPI receive FIFO, drives the 8-bit
// register bus and pushes ACK / read data / error bytes to the transmit FIFO.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int RX_LATENCY     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_avail,
  output logic       rx_trig_read,
  input  logic [7:0] rx_data,
  input  logic       tx_full,
  output logic       tx_trig_write,
  output logic [7:0] tx_data,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       frame_err
);

  // Handshakes: rx_trig_read pops one byte only while rx_avail=1, and that
  // byte is sampled RX_LATENCY cycles later; tx_trig_write pushes tx_data
  // only in a cycle where tx_full=0, otherwise the byte and state are held.

  state_e state_q, state_d;

  logic [RX_LATENCY-1:0] lat_q;
  logic       byte_valid, pending, want_byte, timed;
  logic       tmo_en, tmo_clr, tmo_expired;
  logic       is_rd_q;
  logic [7:0] base_q, off_q, wdata_q, tx_hold_q;
  logic [8:0] rem_q;

  assign byte_valid = lat_q[RX_LATENCY-1];
  assign pending    = |lat_q;
  assign timed      = (state_q == ST_GET_ADDR) || (state_q == ST_GET_LEN) ||
                      (state_q == ST_WR_DATA);
  assign tmo_en     = timed && !byte_valid;
  assign tmo_clr    = !tmo_en;

  spi_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    want_byte     = 1'b0;
    tx_trig_write = 1'b0;
    reg_we        = 1'b0;
    reg_re        = 1'b0;
    frame_err     = 1'b0;
    case (state_q)
      ST_IDLE: if (rx_avail) state_d = ST_GET_OP;
      ST_GET_OP: begin
        want_byte = 1'b1;
        if (byte_valid) begin
          state_d = ((rx_data == OP_WRITE) || (rx_data == OP_READ)) ? ST_GET_ADDR : ST_ERR;
        end
      end
      ST_GET_ADDR: begin
        want_byte = 1'b1;
        if (byte_valid)       state_d = ST_GET_LEN;
        else if (tmo_expired) state_d = ST_ERR;
      end
      ST_GET_LEN: begin
        want_byte = 1'b1;
        if (byte_valid)       state_d = is_rd_q ? ST_RD_REQ : ST_WR_DATA;
        else if (tmo_expired) state_d = ST_ERR;
      end
      ST_WR_DATA: begin
        want_byte = 1'b1;
        if (byte_valid)       state_d = ST_WR_STB;
        else if (tmo_expired) state_d = ST_ERR;
      end
      ST_WR_STB: begin
        reg_we  = 1'b1;
        state_d = (rem_q == 9'd1) ? ST_RSP : ST_WR_DATA;
      end
      ST_RD_REQ: begin
        reg_re  = 1'b1;
        state_d = ST_RD_CAP;
      end
      ST_RD_CAP: state_d = ST_RSP;
      ST_RSP: begin
        if (!tx_full) begin
          tx_trig_write = 1'b1;
          state_d = (is_rd_q && (rem_q != 9'd0)) ? ST_RD_REQ : ST_IDLE;
        end
      end
      ST_ERR: begin
        if (!tx_full) begin
          tx_trig_write = 1'b1;
          frame_err     = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A pop is never launched in the cycle the watchdog fires, so no byte is lost.
  assign rx_trig_read = want_byte && rx_avail && !pending && !tmo_expired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_q     <= '0;
      is_rd_q   <= 1'b0;
      base_q    <= '0;
      off_q     <= '0;
      wdata_q   <= '0;
      tx_hold_q <= '0;
      rem_q     <= '0;
    end else begin
      lat_q[0] <= rx_trig_read;
      for (int i = 1; i < RX_LATENCY; i++) lat_q[i] <= lat_q[i-1];
      case (state_q)
        ST_GET_OP:   if (byte_valid) is_rd_q <= (rx_data == OP_READ);
        ST_GET_ADDR: if (byte_valid) base_q <= rx_data;
        ST_GET_LEN: begin
          if (byte_valid) begin
            rem_q <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            off_q <= '0;
          end
        end
        ST_WR_DATA: if (byte_valid) wdata_q <= rx_data;
        ST_WR_STB: begin
          off_q     <= off_q + 8'd1;
          rem_q     <= rem_q - 9'd1;
          tx_hold_q <= RSP_ACK;
        end
        ST_RD_CAP: begin
          tx_hold_q <= reg_rdata;
          off_q     <= off_q + 8'd1;
          rem_q     <= rem_q - 9'd1;
        end
        default: ;
      endcase
      if (state_d == ST_ERR) tx_hold_q <= RSP_ERR;
    end
  end

  assign reg_addr  = base_q + off_q;
  assign reg_wdata = wdata_q;
  assign tx_data   = tx_hold_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed and randomized frames against a frame-level reference model of the
// SPI command decoder, with FIFO and register-bus models around the DUT.
module tb_spi_cmd_decoder;

  localparam int TMO = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_avail, rx_trig_read, tx_full, tx_trig_write;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] tx_data, reg_addr, reg_wdata, reg_rdata = 8'h00;
  logic       reg_we, reg_re, busy, frame_err;

  int checks = 0;
  int failures = 0;

  // clock
  always #5 clk = ~clk;

  spi_cmd_decoder #(.TIMEOUT_CYCLES(TMO), .RX_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .rx_avail(rx_avail), .rx_trig_read(rx_trig_read),
    .rx_data(rx_data), .tx_full(tx_full), .tx_trig_write(tx_trig_write),
    .tx_data(tx_data), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy),
    .frame_err(frame_err)
  );

  // receive FIFO model (read latency 1)
  logic [7:0] rx_buf [0:4095];
  int  wr_ptr = 0;
  int  rd_ptr = 0;
  logic avail_en = 1'b1;
  assign rx_avail = avail_en && (rd_ptr != wr_ptr);
  always @(posedge clk) begin
    if (rx_trig_read) begin
      rx_data <= rx_buf[rd_ptr[11:0]];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  // register model: read data is addr ^ 0x5A, one cycle after reg_re
  always @(posedge clk) if (reg_re) reg_rdata <= reg_addr ^ 8'h5A;

  // bus monitor, sampled mid-cycle
  logic [7:0] wa_log [0:1023];
  logic [7:0] wd_log [0:1023];
  logic [7:0] ra_log [0:1023];
  logic [7:0] tx_log [0:1023];
  int wr_n = 0, rd_n = 0, tx_n = 0, err_n = 0, viol = 0;
  logic p_we = 0, p_re = 0, p_tx = 0, p_rx = 0;
  always @(negedge clk) begin
    if (reg_we) begin
      wa_log[wr_n[9:0]] <= reg_addr;
      wd_log[wr_n[9:0]] <= reg_wdata;
      wr_n <= wr_n + 1;
    end
    if (reg_re) begin
      ra_log[rd_n[9:0]] <= reg_addr;
      rd_n <= rd_n + 1;
    end
    if (tx_trig_write) begin
      tx_log[tx_n[9:0]] <= tx_data;
      tx_n <= tx_n + 1;
    end
    if (frame_err) err_n <= err_n + 1;
    if ((tx_trig_write && tx_full) || (reg_we && reg_re) || (reg_we && p_we) ||
        (reg_re && p_re) || (tx_trig_write && p_tx) || (rx_trig_read && p_rx) ||
        (rx_trig_read && !rx_avail))
      viol <= viol + 1;
    p_we <= reg_we; p_re <= reg_re; p_tx <= tx_trig_write; p_rx <= rx_trig_read;
  end

  // scoreboard
  logic [7:0] frame_b[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_wa[$];
  logic [7:0] exp_wd[$];
  logic [7:0] exp_ra[$];
  int exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // frame-level model: walks the byte stream and lists the bus/tx effects
  task automatic model_frames();
    int i, n;
    logic [7:0] a;
    exp_q.delete(); exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
    exp_err = 0;
    i = 0;
    while (i < frame_b.size()) begin
      if (frame_b[i] == 8'h01 || frame_b[i] == 8'h02) begin
        a = frame_b[i+1];
        n = (frame_b[i+2] == 0) ? 256 : int'(frame_b[i+2]);
        for (int k = 0; k < n; k++) begin
          if (frame_b[i] == 8'h01) begin
            exp_wa.push_back(8'(a + k));
            exp_wd.push_back(frame_b[i+3+k]);
          end else begin
            exp_ra.push_back(8'(a + k));
            exp_q.push_back(8'(a + k) ^ 8'h5A);
          end
        end
        if (frame_b[i] == 8'h01) begin
          exp_q.push_back(8'hA5);
          i += 3 + n;
        end else begin
          i += 3;
        end
      end else begin
        exp_q.push_back(8'hEE);
        exp_err++;
        i += 1;
      end
    end
  endtask

  task automatic load_bytes();
    foreach (frame_b[k]) begin
      rx_buf[wr_ptr[11:0]] = frame_b[k];
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic run_frames(input string tag, input bit rand_avail, input bit rand_full);
    int s_wr, s_rd, s_tx, s_err;
    bit done;
    s_wr = wr_n; s_rd = rd_n; s_tx = tx_n; s_err = err_n;
    model_frames();
    load_bytes();
    done = 0;
    for (int cyc = 0; cyc < 8000 && !done; cyc++) begin
      @(posedge clk); #1;
      if (rand_avail) avail_en = ($urandom_range(0, 3) != 0);
      if (rand_full)  tx_full  = ($urandom_range(0, 1) == 1);
      if (rd_ptr == wr_ptr && !busy) done = 1;
    end
    avail_en = 1'b1; tx_full = 1'b0;
    repeat (2) @(posedge clk); #1;
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_wr_cnt"}, wr_n - s_wr, exp_wa.size());
    check({tag, "_rd_cnt"}, rd_n - s_rd, exp_ra.size());
    check({tag, "_tx_cnt"}, tx_n - s_tx, exp_q.size());
    check({tag, "_err_cnt"}, err_n - s_err, exp_err);
    check({tag, "_viol"}, viol, 0);
    foreach (exp_wa[k]) begin
      check({tag, "_wr_addr"}, wa_log[10'(s_wr + k)], exp_wa[k]);
      check({tag, "_wr_data"}, wd_log[10'(s_wr + k)], exp_wd[k]);
    end
    foreach (exp_ra[k]) check({tag, "_rd_addr"}, ra_log[10'(s_rd + k)], exp_ra[k]);
    foreach (exp_q[k])  check({tag, "_tx_byte"}, tx_log[10'(s_tx + k)], exp_q[k]);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_strobes"}, {rx_trig_read, tx_trig_write, reg_we, reg_re, frame_err}, 0);
    check({tag, "_buses"}, {reg_addr, reg_wdata, tx_data}, 0);
  endtask

  initial begin
    int s_wr, s_tx, s_err, cyc, v, len;
    bit ok;
    tx_full = 1'b0;

    // reset
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("idle_busy", busy, 0);

    // WRITE 01 10 03 AA BB CC
    frame_b = '{8'h01, 8'h10, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    run_frames("write3", 0, 0);

    // READ 02 FE 03 with address wrap
    frame_b = '{8'h02, 8'hFE, 8'h03};
    run_frames("read_wrap", 0, 0);

    // unknown opcode then a normal frame
    frame_b = '{8'h7F, 8'h01, 8'h00, 8'h01, 8'h11};
    run_frames("bad_op", 0, 0);

    // timeout mid-WRITE
    s_wr = wr_n; s_tx = tx_n; s_err = err_n;
    frame_b = '{8'h01, 8'h20, 8'h02, 8'hAA};
    load_bytes();
    ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(posedge clk); #1;
      if (rd_ptr == wr_ptr) ok = 1;
    end
    check("tmo_bytes_taken", 32'(ok), 1);
    cyc = 0;
    while (err_n == s_err && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("tmo_delay_in_range", 32'(cyc >= TMO - 5 && cyc <= TMO + 10), 1);
    repeat (3) @(posedge clk); #1;
    check("tmo_busy", busy, 0);
    check("tmo_wr_cnt", wr_n - s_wr, 1);
    check("tmo_wr_addr", wa_log[10'(s_wr)], 8'h20);
    check("tmo_wr_data", wd_log[10'(s_wr)], 8'hAA);
    check("tmo_tx_cnt", tx_n - s_tx, 1);
    check("tmo_tx_byte", tx_log[10'(s_tx)], 8'hEE);
    check("tmo_err_cnt", err_n - s_err, 1);

    // 256-byte READ with tx_full toggling
    frame_b = '{8'h02, 8'h00, 8'h00};
    run_frames("read256", 0, 1);

    // randomized frame mix with rx gaps and tx back-pressure
    frame_b.delete();
    for (int f = 0; f < 14; f++) begin
      v = $urandom_range(0, 9);
      if (v <= 4) begin
        len = $urandom_range(1, 8);
        frame_b.push_back(8'h01);
        frame_b.push_back(8'($urandom_range(0, 255)));
        frame_b.push_back(8'(len));
        for (int k = 0; k < len; k++) frame_b.push_back(8'($urandom_range(0, 255)));
      end else if (v <= 8) begin
        frame_b.push_back(8'h02);
        frame_b.push_back(8'($urandom_range(0, 255)));
        frame_b.push_back(8'($urandom_range(1, 6)));
      end else begin
        v = $urandom_range(3, 255);
        frame_b.push_back(8'(v));
      end
    end
    run_frames("random", 1, 1);

    // asynchronous reset mid-WRITE after one data byte
    s_wr = wr_n; s_tx = tx_n; s_err = err_n;
    frame_b = '{8'h01, 8'h40, 8'h03, 8'h11};
    load_bytes();
    cyc = 0;
    while (wr_n == s_wr && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_first_write_seen", wr_n - s_wr, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_outputs_zero("rst_async");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (TMO + 20) @(posedge clk);
    #1;
    check("rst_no_more_writes", wr_n - s_wr, 1);
    check("rst_no_response", tx_n - s_tx, 0);
    check("rst_no_err", err_n - s_err, 0);
    check("rst_busy", busy, 0);
    frame_b = '{8'h02, 8'h30, 8'h01};
    run_frames("after_rst", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
